// File: rtl/web_command_sequencer.sv
// Command engine that drives the web shooter trigger/refill interface from a
// small FIFO of host commands and reports one response code per command.
module web_command_sequencer #(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT     = 16,
   parameter int REFILL_HOLD = 4,
   parameter int GAP         = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_op,
   input  logic [2:0]               cmd_mode,
   input  logic [4:0]               cmd_targets,
   input  logic [2:0]               shoot_cnt,
   output logic                     trigger,
   output logic                     refill,
   output logic [2:0]               fire_mode,
   output logic [4:0]               target_cnt,
   output logic                     rsp_valid,
   output logic [1:0]               rsp_code,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (TIMEOUT > REFILL_HOLD) ?
                         ((TIMEOUT > GAP) ? TIMEOUT : GAP) :
                         ((REFILL_HOLD > GAP) ? REFILL_HOLD : GAP);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] RF_LAST  = TW'(REFILL_HOLD - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] CODE_FAIL   = 2'b01;
   localparam logic [1:0] CODE_REFILL = 2'b10;
   localparam logic [1:0] CODE_SHOT   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETUP   = 2'd1,
      S_ASSERT  = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   // Valid/ready: a command is taken on any rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready depends on the registered count only.
   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [8:0]    head;
   logic          push;
   logic          pop;

   assign cmd_ready  = (count_q < FULL_CNT);
   assign push       = cmd_valid && cmd_ready;
   assign head       = mem_q[rd_ptr_q];
   assign fifo_count = count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_op, cmd_mode, cmd_targets};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    base_q, base_d;
   logic [1:0]    code_q, code_d;
   logic [1:0]    rsp_code_q;
   logic          op_q;
   logic [2:0]    mode_q;
   logic [4:0]    targets_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         base_q     <= '0;
         code_q     <= '0;
         rsp_code_q <= '0;
         op_q       <= 1'b0;
         mode_q     <= '0;
         targets_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         base_q  <= base_d;
         code_q  <= code_d;
         if (rsp_valid) rsp_code_q <= code_q;
         // A refill leaves the last fire mode/targets on the bus.
         if (pop) begin
            op_q <= head[8];
            if (!head[8]) begin
               mode_q    <= head[7:5];
               targets_q <= head[4:0];
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      base_d    = base_q;
      code_d    = code_q;
      pop       = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            base_d  = shoot_cnt;
            timer_d = '0;
            state_d = S_ASSERT;
         end
         S_ASSERT: begin
            timer_d = timer_q + TW'(1);
            if (!op_q) begin
               // Any counter movement is a shot, and it outranks a timeout.
               if (shoot_cnt != base_q) begin
                  code_d  = CODE_SHOT;
                  timer_d = '0;
                  state_d = S_RELEASE;
               end else if (timer_q == TO_LAST) begin
                  code_d  = CODE_FAIL;
                  timer_d = '0;
                  state_d = S_RELEASE;
               end
            end else if (timer_q == RF_LAST) begin
               code_d  = CODE_REFILL;
               timer_d = '0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            timer_d = timer_q + TW'(1);
            if (timer_q == GAP_LAST) begin
               rsp_valid = 1'b1;
               timer_d   = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign trigger    = (state_q == S_ASSERT) && !op_q;
   assign refill     = (state_q == S_ASSERT) && op_q;
   assign fire_mode  = mode_q;
   assign target_cnt = targets_q;
   assign rsp_code   = rsp_valid ? code_q : rsp_code_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_web_command_sequencer.sv
// Directed and randomized bench for web_command_sequencer with a command-level
// reference model (expected queue plus per-command timing arithmetic).
module tb_web_command_sequencer;

   localparam int DEPTH       = 4;
   localparam int TIMEOUT     = 16;
   localparam int REFILL_HOLD = 4;
   localparam int GAP         = 2;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   logic [2:0] cmd_mode;
   logic [4:0] cmd_targets;
   logic [2:0] shoot_cnt;
   logic       trigger;
   logic       refill;
   logic [2:0] fire_mode;
   logic [4:0] target_cnt;
   logic       rsp_valid;
   logic [1:0] rsp_code;
   logic       busy;
   logic [2:0] fifo_count;

   web_command_sequencer #(
      .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .REFILL_HOLD(REFILL_HOLD), .GAP(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_targets(cmd_targets),
      .shoot_cnt(shoot_cnt), .trigger(trigger), .refill(refill),
      .fire_mode(fire_mode), .target_cnt(target_cnt), .rsp_valid(rsp_valid),
      .rsp_code(rsp_code), .busy(busy), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] exp_q[$];
   int         tests;
   int         fails;
   logic [2:0] mdl_mode;
   logic [4:0] mdl_tg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge (the drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic op, input logic [2:0] m, input logic [4:0] t);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_mode    = m;
      cmd_targets = t;
      #1;
      chk("push_ready", cmd_ready, 1);
      @(posedge clk);
      exp_q.push_back({op, m, t});
      #1;
      cmd_valid = 1'b0;
   endtask

   // Follows the oldest expected command from pop to response. shot_at is the
   // ASSERT cycle in which shoot_cnt moves by delta (0 or beyond TIMEOUT: never).
   task automatic exec_check(input int shot_at, input int delta, input int exp_wait);
      logic [8:0] c;
      logic       op;
      logic [2:0] m;
      logic [4:0] t;
      logic [1:0] code;
      int         n;
      int         waited;
      if (exp_q.size() == 0) return;
      c = exp_q.pop_front();
      {op, m, t} = c;
      if (op) begin
         n = REFILL_HOLD; code = 2'b10;
      end else if (shot_at >= 1 && shot_at <= TIMEOUT) begin
         n = shot_at; code = 2'b11;
      end else begin
         n = TIMEOUT; code = 2'b01;
      end
      if (!op) begin
         mdl_mode = m;
         mdl_tg   = t;
      end
      waited = 0;
      do begin
         step(); #1; waited++;
      end while (!busy && waited < 200);
      chk("setup_busy", busy, 1);
      if (exp_wait > 0) chk("pop_spacing", waited, exp_wait);
      chk("setup_outputs_low", {trigger, refill}, 0);
      chk("setup_mode", fire_mode, mdl_mode);
      chk("setup_targets", target_cnt, mdl_tg);
      chk("setup_fifo_count", fifo_count, exp_q.size());
      for (int i = 1; i <= n; i++) begin
         step();
         if (!op && i == shot_at) shoot_cnt = shoot_cnt + delta[2:0];
         #1;
         chk("assert_trigger", trigger, !op);
         chk("assert_refill", refill, op);
         chk("assert_mode_targets", {fire_mode, target_cnt}, {mdl_mode, mdl_tg});
         chk("assert_no_rsp", rsp_valid, 0);
      end
      for (int g = 1; g <= GAP; g++) begin
         step();
         shoot_cnt = 3'($urandom_range(0, 7));
         #1;
         chk("release_outputs_low", {trigger, refill}, 0);
         chk("release_mode_targets", {fire_mode, target_cnt}, {mdl_mode, mdl_tg});
         chk("release_rsp_valid", rsp_valid, (g == GAP));
         if (g == GAP) chk("rsp_code", rsp_code, code);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1, "watchdog");
   end

   initial begin
      int mdl_cnt;
      int pre;
      bit mdl_idle;
      bit acc;
      int k;
      int sa;
      logic [8:0] c0;

      tests = 0; fails = 0;
      mdl_mode = '0; mdl_tg = '0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_mode = '0;
      cmd_targets = '0; shoot_cnt = '0;
      #3;
      chk("rst_trigger", trigger, 0);
      chk("rst_refill", refill, 0);
      chk("rst_fire_mode", fire_mode, 0);
      chk("rst_target_cnt", target_cnt, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_code", rsp_code, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      #10 rst_n = 1'b1;
      step();

      // Refill on an empty FIFO.
      push(1'b1, 3'd0, 5'd0);
      exec_check(0, 0, 1);

      // Fire with shot in the 3rd ASSERT cycle (2 -> 3).
      shoot_cnt = 3'd2;
      push(1'b0, 3'b011, 5'd4);
      exec_check(3, 1, 1);

      // Fire with no shot: full timeout.
      push(1'b0, 3'b101, 5'd17);
      exec_check(0, 0, 1);

      // Counter wraps 7 -> 0.
      step();
      shoot_cnt = 3'd7;
      push(1'b0, 3'b001, 5'd31);
      exec_check(5, 1, 1);

      // Shot in the final cycle before timeout still counts as a shot.
      push(1'b0, 3'b010, 5'd2);
      exec_check(TIMEOUT, 3, 1);

      // Burst of 6 pushes while a refill keeps the engine busy.
      push(1'b1, 3'd0, 5'd0);
      mdl_cnt = 1; mdl_idle = 1'b1;
      for (int a = 0; a < 6; a++) begin
         cmd_valid   = 1'b1;
         cmd_op      = 1'($urandom_range(0, 1));
         cmd_mode    = 3'($urandom_range(0, 5));
         cmd_targets = 5'($urandom_range(0, 31));
         #1;
         chk("burst_ready", cmd_ready, (mdl_cnt < DEPTH));
         chk("burst_count", fifo_count, mdl_cnt);
         acc = (mdl_cnt < DEPTH);
         @(posedge clk);
         pre = mdl_cnt;
         if (acc) begin
            exp_q.push_back({cmd_op, cmd_mode, cmd_targets});
            mdl_cnt++;
         end
         if (mdl_idle && pre > 0) begin
            mdl_cnt--;
            mdl_idle = 1'b0;
         end
         #1;
      end
      cmd_valid = 1'b0;
      #1;
      chk("burst_final_count", fifo_count, mdl_cnt);
      chk("burst_full_ready", cmd_ready, (mdl_cnt < DEPTH));
      c0 = exp_q.pop_front();
      k = 0;
      do begin
         step(); #1; k++;
      end while (!rsp_valid && k < 40);
      chk("burst_first_rsp_seen", rsp_valid, 1);
      chk("burst_first_rsp_code", rsp_code, c0[8] ? 2'b10 : 2'b01);
      for (int b = 0; b < 4; b++) begin
         exec_check($urandom_range(1, TIMEOUT + 4), $urandom_range(1, 7), 2);
      end

      // Randomized single commands with idle gaps and stray counter motion.
      for (int r = 0; r < 20; r++) begin
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) begin
            step();
            shoot_cnt = 3'($urandom_range(0, 7));
         end
         push(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 5'($urandom_range(0, 31)));
         exec_check($urandom_range(1, TIMEOUT + 6), $urandom_range(1, 7), 1);
      end

      // Reset in the middle of a fire with two commands queued.
      push(1'b0, 3'b010, 5'd9);
      push(1'b1, 3'd0, 5'd0);
      push(1'b1, 3'd0, 5'd0);
      k = 0;
      do begin
         step(); #1; k++;
      end while (!trigger && k < 20);
      step(); step();
      #1;
      chk("pre_reset_trigger", trigger, 1);
      chk("pre_reset_count", fifo_count, 2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_trigger", trigger, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_count", fifo_count, 0);
      chk("async_rst_rsp", {rsp_valid, rsp_code}, 0);
      chk("async_rst_mode_targets", {fire_mode, target_cnt}, 0);
      exp_q.delete();
      mdl_mode = '0; mdl_tg = '0;
      #20 rst_n = 1'b1;
      for (int q = 0; q < 25; q++) begin
         step(); #1;
         chk("post_reset_quiet", {rsp_valid, busy, trigger, refill}, 0);
      end
      push(1'b1, 3'd0, 5'd0);
      exec_check(0, 0, 1);
      sa = $urandom_range(1, TIMEOUT);
      push(1'b0, 3'b100, 5'd12);
      exec_check(sa, 2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/web_command_sequencer.md
Name: web_command_sequencer

Overview:
- Initiator side of the web shooter trigger/refill interface.
- Accepts queued fire/refill commands from a host through a valid/ready port and buffers them in a FIFO.
- Drives trigger, refill, fire_mode and target_cnt into the web shooter controller one command at a time, observing its 3-bit shoot counter.
- Returns one response code per command; replaces hand-timed testbench stimulus with a reusable, cycle-exact command engine.

Parameters:
- DEPTH, 4: command FIFO entries (power of two, >=2).
- TIMEOUT, 16: max cycles trigger is held without a shot before the fire attempt is abandoned.
- REFILL_HOLD, 4: cycles refill is held high per refill command.
- GAP, 2: cycles trigger and refill are both low after each command, so the controller returns to waiting.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  1  0 = fire, 1 = refill
- cmd_mode  in  3  fire mode code (swing 000 ... tracer 101)
- cmd_targets  in  5  target count for the fire command
- shoot_cnt  in  3  shot counter from the web shooter
- trigger  out  1  trigger to the web shooter
- refill  out  1  refill request to the web shooter
- fire_mode  out  3  mode presented to the web shooter
- target_cnt  out  5  target count presented to the web shooter
- rsp_valid  out  1  one-cycle response strobe
- rsp_code  out  2  01 = insufficient/timeout, 10 = refill done, 11 = shot fired; 00 is never emitted
- busy  out  1  FSM not in IDLE
- fifo_count  out  log2(DEPTH)+1  entries held

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs take their reset values immediately: trigger = 0, refill = 0, fire_mode = 000, target_cnt = 0, rsp_valid = 0, rsp_code = 00, busy = 0, fifo_count = 0.
- FIFO is flushed and the FSM returns to IDLE.
- Reset mid-command aborts that command with no response.

FIFO:
- Push occurs when cmd_valid && cmd_ready.
- cmd_ready = (fifo_count < DEPTH), derived from the registered count only. A push is refused when full even if a pop occurs in the same cycle.
- Simultaneous push and pop with a non-full FIFO leaves fifo_count unchanged.
- Commands are issued in FIFO order; pointers wrap modulo DEPTH.

FSM states: IDLE, SETUP, ASSERT, RELEASE.
- IDLE: if fifo_count > 0, pop the head and register op, mode and targets, then go to SETUP. Otherwise stay.
- SETUP (1 cycle):
  - fire_mode and target_cnt take the command values; trigger = refill = 0.
  - shoot_cnt is latched as the baseline.
  - Timer is cleared; next state is ASSERT.
  - For a refill, fire_mode and target_cnt keep their previous values.
- ASSERT, fire:
  - trigger = 1 and the timer increments each cycle.
  - If shoot_cnt != baseline, the code is 11 and the next state is RELEASE. Any change counts, including wrap 7->0.
  - Else if the timer reaches TIMEOUT, the code is 01 and the next state is RELEASE. trigger is therefore high for exactly TIMEOUT cycles.
  - If a shot and timeout coincide, the shot wins.
- ASSERT, refill: refill = 1 for exactly REFILL_HOLD cycles; the code is 10 and the next state is RELEASE.
- RELEASE:
  - trigger = refill = 0 for GAP cycles.
  - On the last cycle, rsp_valid = 1 for one cycle with rsp_code; the next state is IDLE.
  - rsp_code holds its value until the next response.
- busy = 1 in SETUP, ASSERT and RELEASE.
- Back-to-back: IDLE may pop on the cycle after the rsp_valid strobe. Minimum inter-command spacing is therefore 1 idle cycle.
- fire_mode and target_cnt are held constant from SETUP through RELEASE.
- shoot_cnt changes outside ASSERT are ignored.
- Latency from pop to rsp_valid:
  - fire: 1 + n + GAP cycles, where n is the number of ASSERT cycles;
  - refill: 1 + REFILL_HOLD + GAP cycles.

Test Plan:
- Refill command on an empty FIFO with defaults -> refill high exactly 4 cycles, low 2 cycles, then rsp_valid with rsp_code = 10; trigger stays 0 throughout.
- Fire command (mode 011, targets 4) with shoot_cnt stepping 2->3 in the 3rd ASSERT cycle -> trigger high 3 cycles, fire_mode = 011 and target_cnt = 4 stable, rsp_code = 11.
- Fire command with shoot_cnt constant -> trigger high exactly 16 cycles, rsp_code = 01.
- shoot_cnt wraps 7->0 during ASSERT -> rsp_code = 11.
- Push 6 commands back-to-back while the FSM is busy (DEPTH = 4) -> cmd_ready drops at fifo_count = 4, exactly 4 accepted, responses in push order; push and pop in the same cycle keeps the count unchanged.
- Assert rst_n low mid-ASSERT with trigger high and 2 queued commands -> trigger drops without a clock edge, fifo_count = 0, no rsp_valid; the next command after reset completes normally.
